// File: rtl/dac_wr_arb.sv
// Round-robin arbiter that shares one serial threshold-DAC write port between
// N_REQ measurement controllers, with a DAC completion timeout.
module dac_wr_arb #(
  parameter int N_REQ       = 4,
  parameter int DAT_W       = 24,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [N_REQ-1:0]       req_wre_i,
  input  logic [N_REQ*DAT_W-1:0] req_dat_i,
  output logic [N_REQ-1:0]       req_ack_o,
  output logic [N_REQ-1:0]       grant_o,
  output logic [DAT_W-1:0]       dac_dat_o,
  output logic                   dac_wre_o,
  input  logic                   dac_rdy_i,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i,
  output logic [1:0]             dbg_state_o
);

  // Handshake: a requester holds req_wre_i high with a stable word until it
  // sees its one-cycle req_ack_o pulse; the word is captured at grant, and a
  // request still high after the ack is treated as a fresh request.

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [DAT_W-1:0]   pick_dat;
  logic [IDX_W-1:0]   ptr_next;

  logic               start;
  logic               done;
  logic               timeout;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (!pick_vld && req_wre_i[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    pick_oh  = '0;
    pick_dat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_oh[i] = pick_vld;
        pick_dat   = req_dat_i[i*DAT_W +: DAT_W];
      end
    end
  end

  assign ptr_next = (gidx_q == IDX_W'(N_REQ-1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && dac_rdy_i) begin
          start   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (dac_rdy_i) begin
          done    = 1'b1;
          state_d = ST_ACK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
          done    = 1'b1;
          timeout = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      ptr_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      grant_o   <= '0;
      req_ack_o <= '0;
      dac_dat_o <= '0;
      dac_wre_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      dac_wre_o <= start;
      req_ack_o <= done ? grant_o : '0;

      if (start) begin
        grant_o   <= pick_oh;
        gidx_q    <= pick_idx;
        dac_dat_o <= pick_dat;
      end else if (state_q == ST_ACK) begin
        grant_o <= '0;
        ptr_q   <= ptr_next;
      end

      if (state_q == ST_ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == ST_WAIT_DONE) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // A timeout in the same cycle as a clear leaves the flag set.
      if (timeout) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
